// File: rtl/acc_cpu_sequencer.sv
// Fetch/execute sequencer for the 4-bit-opcode accumulator CPU.
// A clocked FSM (IDLE/FETCH/EXEC/HALTED/FAULT) handshakes with instruction
// memory and decodes the IR opcode into the datapath strobes during EXEC.
// All outputs are combinational from state and the live status inputs.
module acc_cpu_sequencer #(
   parameter int FETCH_TIMEOUT = 15,  // 1..255 consecutive not-ready FETCH cycles
   parameter int CNT_W         = 16
) (
   input  logic             CLK,
   input  logic             CLB,
   input  logic             Run,
   input  logic             Step,
   input  logic             MemReady,
   input  logic [3:0]       Opcode,
   input  logic             Z,
   input  logic             C,
   output logic             MemReq,
   output logic             LoadIR,
   output logic             IncPC,
   output logic             SelPC,
   output logic             LoadPC,
   output logic             LoadReg,
   output logic             LoadAcc,
   output logic [1:0]       SelAcc,
   output logic [3:0]       SelALU,
   output logic             Busy,
   output logic             Halted,
   output logic             Fault,
   output logic [CNT_W-1:0] InstrCount
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_EXEC   = 3'd2,
      S_HALTED = 3'd3,
      S_FAULT  = 3'd4
   } state_t;

   state_t           r_state;
   state_t           w_next;
   logic [7:0]       r_tmo;
   logic             r_step;
   logic [CNT_W-1:0] r_cnt;

   logic [7:0]       w_tmo_inc;
   logic             w_tmo_hit;
   logic             w_halt;
   logic             w_illegal;
   logic             w_retire;

   assign w_tmo_inc = r_tmo + 8'd1;
   assign w_tmo_hit = (w_tmo_inc == 8'(FETCH_TIMEOUT));
   assign w_halt    = (Opcode == 4'b1111);
   assign w_illegal = (Opcode == 4'b1001) || (Opcode == 4'b1110);
   // An instruction retires when its EXEC cycle is neither HALT nor illegal.
   assign w_retire  = (r_state == S_EXEC) && !w_halt && !w_illegal;

   // State register; reset wins over every transition.
   always_ff @(posedge CLK) begin
      if (CLB) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   // Next-state logic.
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:   if (Run || Step) w_next = S_FETCH;
         S_FETCH: begin
            if (MemReady)       w_next = S_EXEC;
            else if (w_tmo_hit) w_next = S_FAULT;
         end
         S_EXEC: begin
            if (w_halt)                w_next = S_HALTED;
            else if (w_illegal)        w_next = S_FAULT;
            else if (Run && !r_step)   w_next = S_FETCH;
            else                       w_next = S_IDLE;
         end
         S_HALTED: w_next = S_HALTED;
         S_FAULT:  w_next = S_FAULT;
         default:  w_next = S_IDLE;
      endcase
   end

   // Fetch timeout counter, single-step latch and saturating retire counter.
   always_ff @(posedge CLK) begin
      if (CLB) begin
         r_tmo  <= '0;
         r_step <= 1'b0;
         r_cnt  <= '0;
      end else begin
         // Counts only consecutive not-ready FETCH cycles; anything else clears it.
         if (r_state == S_FETCH && !MemReady) r_tmo <= w_tmo_inc;
         else                                 r_tmo <= '0;
         // Step only arms single-step mode when it actually starts a fetch
         // from IDLE; Run takes precedence and gives continuous mode.
         if (r_state == S_IDLE && !Run && Step) r_step <= 1'b1;
         else if (r_state == S_EXEC)            r_step <= 1'b0;
         if (w_retire && (r_cnt != {CNT_W{1'b1}})) r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   // Output decode; every strobe defaults low.
   always_comb begin
      MemReq  = 1'b0;
      LoadIR  = 1'b0;
      IncPC   = 1'b0;
      SelPC   = 1'b0;
      LoadPC  = 1'b0;
      LoadReg = 1'b0;
      LoadAcc = 1'b0;
      SelAcc  = 2'b00;
      SelALU  = 4'b0000;
      case (r_state)
         S_FETCH: begin
            MemReq = 1'b1;
            LoadIR = MemReady;
         end
         S_EXEC: begin
            case (Opcode)
               4'b0001, 4'b0010, 4'b0011, 4'b1011, 4'b1100: begin
                  LoadAcc = 1'b1;
                  SelAcc  = 2'b01;
                  SelALU  = Opcode;
                  IncPC   = 1'b1;
               end
               4'b0100: begin
                  LoadAcc = 1'b1;
                  SelAcc  = 2'b10;
                  IncPC   = 1'b1;
               end
               4'b0101: begin
                  LoadReg = 1'b1;
                  IncPC   = 1'b1;
               end
               4'b1101: begin
                  LoadAcc = 1'b1;
                  IncPC   = 1'b1;
               end
               // Conditional jumps: taken loads PC, otherwise fall through.
               4'b0110: begin
                  LoadPC = Z;
                  IncPC  = !Z;
               end
               4'b0111: begin
                  LoadPC = Z;
                  SelPC  = Z;
                  IncPC  = !Z;
               end
               4'b1000: begin
                  LoadPC = C;
                  IncPC  = !C;
               end
               4'b1010: begin
                  LoadPC = C;
                  SelPC  = C;
                  IncPC  = !C;
               end
               4'b0000: IncPC = 1'b1;
               default: ;  // HALT and illegal opcodes drive nothing
            endcase
         end
         default: ;
      endcase
   end

   assign Busy       = (r_state == S_FETCH) || (r_state == S_EXEC);
   assign Halted     = (r_state == S_HALTED);
   assign Fault      = (r_state == S_FAULT);
   assign InstrCount = r_cnt;

endmodule

// File: tb/tb_acc_cpu_sequencer.sv
// Directed bench for acc_cpu_sequencer: a default instance plus a CNT_W=4
// instance sharing all inputs, used to observe counter saturation.
module tb_acc_cpu_sequencer;

   logic        CLK = 1'b0;
   logic        CLB, Run, Step, MemReady, Z, C;
   logic [3:0]  Opcode;
   logic        MemReq, LoadIR, IncPC, SelPC, LoadPC, LoadReg, LoadAcc, Busy, Halted, Fault;
   logic [1:0]  SelAcc;
   logic [3:0]  SelALU;
   logic [15:0] InstrCount;
   logic        s_MemReq, s_LoadIR, s_IncPC, s_SelPC, s_LoadPC, s_LoadReg, s_LoadAcc;
   logic        s_Busy, s_Halted, s_Fault;
   logic [1:0]  s_SelAcc;
   logic [3:0]  s_SelALU;
   logic [3:0]  s_InstrCount;

   // {MemReq,LoadIR,IncPC,SelPC,LoadPC,LoadReg,LoadAcc,SelAcc[1:0]}
   logic [8:0]  strb;
   logic [2:0]  stat;
   assign strb = {MemReq, LoadIR, IncPC, SelPC, LoadPC, LoadReg, LoadAcc, SelAcc};
   assign stat = {Busy, Halted, Fault};

   int n_chk  = 0;
   int n_fail = 0;

   always #5 CLK = ~CLK;

   acc_cpu_sequencer u_dut (
      .CLK(CLK), .CLB(CLB), .Run(Run), .Step(Step), .MemReady(MemReady),
      .Opcode(Opcode), .Z(Z), .C(C),
      .MemReq(MemReq), .LoadIR(LoadIR), .IncPC(IncPC), .SelPC(SelPC),
      .LoadPC(LoadPC), .LoadReg(LoadReg), .LoadAcc(LoadAcc), .SelAcc(SelAcc),
      .SelALU(SelALU), .Busy(Busy), .Halted(Halted), .Fault(Fault),
      .InstrCount(InstrCount)
   );

   acc_cpu_sequencer #(.FETCH_TIMEOUT(15), .CNT_W(4)) u_sat (
      .CLK(CLK), .CLB(CLB), .Run(Run), .Step(Step), .MemReady(MemReady),
      .Opcode(Opcode), .Z(Z), .C(C),
      .MemReq(s_MemReq), .LoadIR(s_LoadIR), .IncPC(s_IncPC), .SelPC(s_SelPC),
      .LoadPC(s_LoadPC), .LoadReg(s_LoadReg), .LoadAcc(s_LoadAcc), .SelAcc(s_SelAcc),
      .SelALU(s_SelALU), .Busy(s_Busy), .Halted(s_Halted), .Fault(s_Fault),
      .InstrCount(s_InstrCount)
   );

   task automatic adv();
      @(posedge CLK);
      #1;
   endtask

   task automatic do_reset();
      CLB = 1'b1; Run = 1'b0; Step = 1'b0; MemReady = 1'b0;
      Opcode = 4'b0000; Z = 1'b0; C = 1'b0;
      adv();
      CLB = 1'b0;
   endtask

   // Single-step one instruction with a zero-wait fetch; returns at the
   // falling edge inside its EXEC cycle.
   task automatic run_one(input logic [3:0] op, input logic zf, input logic cf);
      Run = 1'b0; Step = 1'b1; MemReady = 1'b1;
      adv();
      Step = 1'b0; Opcode = op; Z = zf; C = cf;
      adv();
      @(negedge CLK);
   endtask

   task automatic test_reset();
      CLB = 1'b1; Run = 1'b1; Step = 1'b1; MemReady = 1'b1;
      Opcode = 4'b0001; Z = 1'b1; C = 1'b1;
      adv(); adv();
      @(negedge CLK);
      n_chk++;
      if (strb !== 9'b0 || SelALU !== 4'b0 || stat !== 3'b000 || InstrCount !== 16'd0) begin
         n_fail++;
         $display("FAIL reset_hold: strb=%b alu=%b stat=%b cnt=%0d, want all zero", strb, SelALU, stat, InstrCount);
      end
      adv();
      CLB = 1'b0; Run = 1'b0; Step = 1'b0;
      @(negedge CLK);
      n_chk++;
      if (strb !== 9'b0 || stat !== 3'b000) begin
         n_fail++;
         $display("FAIL reset_after: strb=%b stat=%b, want 0/0", strb, stat);
      end
      adv();
   endtask

   task automatic test_run_program();
      do_reset();
      Run = 1'b1; MemReady = 1'b1; Opcode = 4'b0000;
      @(negedge CLK);
      n_chk++;
      if (strb !== 9'b0 || stat !== 3'b000) begin
         n_fail++; $display("FAIL prog_idle: strb=%b stat=%b, want 0/000", strb, stat);
      end
      adv();
      @(negedge CLK);
      n_chk++;
      if (strb !== 9'b110000000 || stat !== 3'b100) begin
         n_fail++; $display("FAIL prog_fetch1: strb=%b stat=%b, want 110000000/100", strb, stat);
      end
      adv();
      @(negedge CLK);
      n_chk++;
      if (strb !== 9'b001000000 || SelALU !== 4'b0) begin
         n_fail++; $display("FAIL prog_nop: strb=%b alu=%b, want 001000000/0000", strb, SelALU);
      end
      adv();
      Opcode = 4'b0001;
      @(negedge CLK);
      n_chk++;
      if (strb !== 9'b110000000) begin
         n_fail++; $display("FAIL prog_fetch2: strb=%b, want 110000000", strb);
      end
      adv();
      @(negedge CLK);
      n_chk++;
      if (strb !== 9'b001000101 || SelALU !== 4'b0001) begin
         n_fail++; $display("FAIL prog_add: strb=%b alu=%b, want 001000101/0001", strb, SelALU);
      end
      adv();
      Opcode = 4'b1111;
      @(negedge CLK);
      n_chk++;
      if (strb !== 9'b110000000) begin
         n_fail++; $display("FAIL prog_fetch3: strb=%b, want 110000000", strb);
      end
      adv();
      @(negedge CLK);
      n_chk++;
      if (strb !== 9'b0 || SelALU !== 4'b0 || stat !== 3'b100) begin
         n_fail++; $display("FAIL prog_halt_exec: strb=%b alu=%b stat=%b, want 0/0/100", strb, SelALU, stat);
      end
      adv();
      @(negedge CLK);
      n_chk++;
      if (stat !== 3'b010 || InstrCount !== 16'd2 || strb !== 9'b0) begin
         n_fail++; $display("FAIL prog_halted: stat=%b cnt=%0d strb=%b, want 010/2/0", stat, InstrCount, strb);
      end
      Step = 1'b1;
      adv(); adv();
      Step = 1'b0;
      @(negedge CLK);
      n_chk++;
      if (stat !== 3'b010 || InstrCount !== 16'd2) begin
         n_fail++; $display("FAIL prog_halt_sticky: stat=%b cnt=%0d, want 010/2", stat, InstrCount);
      end
   endtask

   task automatic test_jumps();
      do_reset();
      run_one(4'b0111, 1'b1, 1'b0);
      n_chk++;
      if (strb !== 9'b000110000 || SelALU !== 4'b0) begin
         n_fail++; $display("FAIL jz_imm_taken: strb=%b alu=%b, want 000110000/0000", strb, SelALU);
      end
      adv();
      run_one(4'b0111, 1'b0, 1'b1);
      n_chk++;
      if (strb !== 9'b001000000) begin
         n_fail++; $display("FAIL jz_imm_not: strb=%b, want 001000000", strb);
      end
      adv();
      run_one(4'b1000, 1'b0, 1'b1);
      n_chk++;
      if (strb !== 9'b000010000) begin
         n_fail++; $display("FAIL jc_reg_taken: strb=%b, want 000010000", strb);
      end
      adv();
      run_one(4'b1000, 1'b1, 1'b0);
      n_chk++;
      if (strb !== 9'b001000000) begin
         n_fail++; $display("FAIL jc_reg_not: strb=%b, want 001000000", strb);
      end
      adv();
      run_one(4'b1010, 1'b0, 1'b1);
      n_chk++;
      if (strb !== 9'b000110000) begin
         n_fail++; $display("FAIL jc_imm_taken: strb=%b, want 000110000", strb);
      end
      adv();
      @(negedge CLK);
      n_chk++;
      if (stat !== 3'b000 || InstrCount !== 16'd5) begin
         n_fail++; $display("FAIL jump_count: stat=%b cnt=%0d, want 000/5", stat, InstrCount);
      end
   endtask

   task automatic test_step();
      do_reset();
      Run = 1'b0; Step = 1'b1; MemReady = 1'b0;
      adv();
      Step = 1'b0;
      for (int i = 0; i < 3; i++) begin
         if (i == 1) Step = 1'b1;
         @(negedge CLK);
         n_chk++;
         if (strb !== 9'b100000000 || stat !== 3'b100) begin
            n_fail++; $display("FAIL step_wait%0d: strb=%b stat=%b, want 100000000/100", i, strb, stat);
         end
         adv();
         Step = 1'b0;
      end
      MemReady = 1'b1; Opcode = 4'b0000;
      @(negedge CLK);
      n_chk++;
      if (strb !== 9'b110000000) begin
         n_fail++; $display("FAIL step_fetch: strb=%b, want 110000000", strb);
      end
      adv();
      @(negedge CLK);
      n_chk++;
      if (strb !== 9'b001000000 || stat !== 3'b100) begin
         n_fail++; $display("FAIL step_exec: strb=%b stat=%b, want 001000000/100", strb, stat);
      end
      adv();
      @(negedge CLK);
      n_chk++;
      if (stat !== 3'b000 || strb !== 9'b0 || InstrCount !== 16'd1) begin
         n_fail++; $display("FAIL step_idle: stat=%b strb=%b cnt=%0d, want 000/0/1", stat, strb, InstrCount);
      end
      adv();
      @(negedge CLK);
      n_chk++;
      if (stat !== 3'b000 || MemReq !== 1'b0) begin
         n_fail++; $display("FAIL step_stays_idle: stat=%b req=%b, want 000/0", stat, MemReq);
      end
   endtask

   task automatic test_timeout();
      do_reset();
      Run = 1'b1; MemReady = 1'b0;
      adv();
      for (int i = 0; i < 15; i++) begin
         @(negedge CLK);
         n_chk++;
         if (strb !== 9'b100000000 || Fault !== 1'b0) begin
            n_fail++; $display("FAIL tmo_fetch%0d: strb=%b fault=%b, want 100000000/0", i, strb, Fault);
         end
         adv();
      end
      @(negedge CLK);
      n_chk++;
      if (stat !== 3'b001 || strb !== 9'b0 || SelALU !== 4'b0) begin
         n_fail++; $display("FAIL tmo_fault: stat=%b strb=%b, want 001/0", stat, strb);
      end
      Step = 1'b1; MemReady = 1'b1;
      adv(); adv();
      Step = 1'b0;
      @(negedge CLK);
      n_chk++;
      if (stat !== 3'b001) begin
         n_fail++; $display("FAIL tmo_sticky: stat=%b, want 001", stat);
      end
      CLB = 1'b1;
      adv();
      @(negedge CLK);
      n_chk++;
      if (stat !== 3'b000 || strb !== 9'b0) begin
         n_fail++; $display("FAIL tmo_clear: stat=%b strb=%b, want 000/0", stat, strb);
      end
      CLB = 1'b0; Run = 1'b0;
      adv();
   endtask

   task automatic test_opcodes();
      do_reset();
      run_one(4'b1110, 1'b1, 1'b1);
      n_chk++;
      if (strb !== 9'b0 || SelALU !== 4'b0) begin
         n_fail++; $display("FAIL illegal_exec: strb=%b alu=%b, want 0/0", strb, SelALU);
      end
      adv();
      @(negedge CLK);
      n_chk++;
      if (stat !== 3'b001 || InstrCount !== 16'd0) begin
         n_fail++; $display("FAIL illegal_fault: stat=%b cnt=%0d, want 001/0", stat, InstrCount);
      end
      do_reset();
      run_one(4'b0101, 1'b0, 1'b0);
      n_chk++;
      if (strb !== 9'b001001000 || SelALU !== 4'b0) begin
         n_fail++; $display("FAIL st_reg: strb=%b alu=%b, want 001001000/0", strb, SelALU);
      end
      adv();
      run_one(4'b1101, 1'b0, 1'b0);
      n_chk++;
      if (strb !== 9'b001000100) begin
         n_fail++; $display("FAIL ld_imm: strb=%b, want 001000100", strb);
      end
      adv();
      run_one(4'b0100, 1'b0, 1'b0);
      n_chk++;
      if (strb !== 9'b001000110) begin
         n_fail++; $display("FAIL ld_reg: strb=%b, want 001000110", strb);
      end
      adv();
      run_one(4'b1100, 1'b0, 1'b0);
      n_chk++;
      if (strb !== 9'b001000101 || SelALU !== 4'b1100) begin
         n_fail++; $display("FAIL shr: strb=%b alu=%b, want 001000101/1100", strb, SelALU);
      end
      adv();
   endtask

   task automatic test_reset_mid_exec();
      do_reset();
      run_one(4'b0000, 1'b0, 1'b0);
      adv();
      @(negedge CLK);
      n_chk++;
      if (InstrCount !== 16'd1) begin
         n_fail++; $display("FAIL midrst_pre: cnt=%0d, want 1", InstrCount);
      end
      run_one(4'b0001, 1'b0, 1'b0);
      n_chk++;
      if (strb !== 9'b001000101 || SelALU !== 4'b0001) begin
         n_fail++; $display("FAIL midrst_add: strb=%b alu=%b, want 001000101/0001", strb, SelALU);
      end
      CLB = 1'b1;
      adv();
      @(negedge CLK);
      n_chk++;
      if (strb !== 9'b0 || SelALU !== 4'b0 || stat !== 3'b000 || InstrCount !== 16'd0) begin
         n_fail++; $display("FAIL midrst_clear: strb=%b alu=%b stat=%b cnt=%0d, want all zero", strb, SelALU, stat, InstrCount);
      end
      CLB = 1'b0;
      adv();
   endtask

   task automatic test_back_to_back();
      do_reset();
      Run = 1'b1; MemReady = 1'b1; Opcode = 4'b0000;
      repeat (41) adv();
      Run = 1'b0;
      @(negedge CLK);
      n_chk++;
      if (InstrCount !== 16'd20 || s_InstrCount !== 4'd15) begin
         n_fail++; $display("FAIL b2b_count: cnt=%0d sat=%0d, want 20/15", InstrCount, s_InstrCount);
      end
      n_chk++;
      if (strb !== 9'b110000000) begin
         n_fail++; $display("FAIL b2b_fetch: strb=%b, want 110000000", strb);
      end
      adv();
      adv();
      @(negedge CLK);
      n_chk++;
      if (stat !== 3'b000 || InstrCount !== 16'd21 || s_InstrCount !== 4'd15 || s_Busy !== 1'b0) begin
         n_fail++; $display("FAIL b2b_stop: stat=%b cnt=%0d sat=%0d, want 000/21/15", stat, InstrCount, s_InstrCount);
      end
   endtask

   initial begin
      test_reset();
      test_run_program();
      test_jumps();
      test_step();
      test_timeout();
      test_opcodes();
      test_reset_mid_exec();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
